inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch stage that sits directly upstream of the single-port synchronous instruction SRAM (`CSN` active low, `WEN` tied high, one-cycle registered read).
- Generates the byte PC and the SRAM word address.
- Absorbs the SRAM read latency in a small prefetch buffer.
- Presents instruction/PC pairs to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/exception) from later stages and discards stale fetches.

Parameters:
- AW, 10, SRAM word-address width; `IM_A = pc[AW+1:2]`
- RESET_PC, 32'h0000_0000, PC loaded at reset
- DEPTH, 2, prefetch buffer entries (power of two, >= 2)

Ports:
- CLK  input  1  clock, all state updates on posedge
- RST  input  1  reset, asynchronous, active-high
- IM_CSN  output  1  SRAM chip select, active low; low = read request this cycle
- IM_A  output  AW  SRAM word address
- IM_DOUT  input  32  SRAM read data, valid the cycle after a request
- redir_valid  input  1  redirect request
- redir_pc  input  32  redirect target (byte address)
- out_valid  output  1  instruction available to decode
- out_ready  input  1  decode accepts this cycle
- out_inst  output  32  instruction word
- out_pc  output  32  byte PC of out_inst

Behaviour:
- Reset (async, RST=1):
  - pc=RESET_PC; buffer empty; in-flight flag=0; state=BOOT.
  - IM_CSN=1, out_valid=0, out_inst=0, out_pc=0.
- States:
  - BOOT: one cycle, no request, then RUN.
  - RUN: normal fetch.
  - FLUSH: one cycle after a redirect, no request, then RUN.
- Request rule (RUN only):
  - IM_CSN=0 iff (buffer count + inflight) < DEPTH, or (count + inflight) == DEPTH and an output handshake occurs this cycle.
  - On request: IM_A=pc[AW+1:2], pc<=pc+4, inflight<=1, req_pc<=pc.
  - IM_CSN and IM_A are combinational from registered state and out_ready only; never from IM_DOUT.
- Response:
  - The cycle after a request, IM_DOUT is written with req_pc into the buffer tail, unless discarded.
  - inflight clears.
- Output:
  - out_valid = buffer not empty; out_inst/out_pc = head entry.
  - Pop on out_valid & out_ready.
  - out_inst/out_pc hold stable while out_valid=1 and out_ready=0.
  - A simultaneous push and pop is permitted. When the buffer is full with a pop this cycle, the push lands in the freed slot.
- Throughput: one instruction per cycle sustained when out_ready=1 continuously.
- Latency: first out_valid 3 cycles after reset deassertion (BOOT, request, data).
- Redirect (redir_valid=1, any state):
  - Buffer cleared; the in-flight response arriving next cycle is discarded.
  - pc<=redir_pc; state<=FLUSH; no handshake reported this cycle (out_valid forced 0).
  - Redirect wins over a simultaneous out_ready, which is ignored.
  - Back-to-back redirects: the last one wins.
- PC arithmetic: 32-bit wrap-around; 32'hFFFF_FFFC+4 = 0.
  - IM_A uses only pc[AW+1:2]; upper bits alias.
  - redir_pc[1:0] is ignored (forced to 0) unless the optional feature is enabled.
- Reset asserted mid-operation: immediate return to reset values. Any SRAM data arriving after reset release is ignored because inflight=0.

Optional Feature:
- Macro `INST_FETCH_MISALIGN_EN`.
- With the macro defined:
  - Extra output `out_misalign` (1 bit), reset 0.
  - A redirect with redir_pc[1:0]!=0 issues no SRAM request. It produces exactly one output entry with out_pc=redir_pc, out_inst=32'h0000_0013 (NOP) and out_misalign=1.
  - Fetch then stalls (no requests) until the next redirect.
- Without the macro: no port; low bits are cleared as above.

Decomposition:
- Shared package `cpu_pkg`:
  - FSM state typedef (BOOT/RUN/FLUSH)
  - RESET_PC default
  - NOP encoding 32'h0000_0013
  - PC increment constant 4
- One natural sub-module, `fetch_buf`:
  - DEPTH-entry synchronous FIFO of {pc, inst}
  - flush input; push/pop same cycle
  - count output; async reset

Test Plan:
- Reset release with out_ready=1, SRAM words 0..3 = 0x11,0x22,0x33,0x44 -> first out_valid 3rd cycle after release; out_pc 0,4,8,C on consecutive cycles with matching inst.
- out_ready=0 for 5 cycles from first valid -> exactly 2 requests issued, IM_CSN=1 thereafter, out_inst holds 0x11; resume -> 0x11,0x22,0x33 with no gap or duplicate.
- Redirect to 0x100 while buffer full and a request in flight -> out_valid=0 for 3 cycles, then out_pc=0x100 with IM_DOUT from word 0x40; stale 0x33 never appears.
- Redirect and out_ready=1 in the same cycle, head pc=0x8 -> pc 0x8 never counted as accepted; next out_pc equals redirect target.
- Redirect to 0xFFFF_FFF8, AW=10 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; IM_A sequence 0x3FE, 0x3FF, 0x000.
- RST pulsed mid-stream (with `INST_FETCH_MISALIGN_EN`, then redirect to 0x102) -> all outputs 0 during reset; after reset normal fetch restarts at 0. After redirect to 0x102: single entry out_pc=0x102, out_inst=0x13, out_misalign=1, then IM_CSN stays 1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: FSM states, reset PC, NOP encoding and PC step.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0013;
    localparam logic [31:0] PC_INC       = 32'd4;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Prefetch FIFO of {pc, inst} entries; flush empties it, push and pop may coincide
// (a push into a full buffer during a pop lands in the slot being freed).
module fetch_buf
    import cpu_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          head_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries data only; occupancy is tracked by the pointers above.
    always_ff @(posedge CLK) begin
        if (push && !flush)
            mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage in front of a one-cycle synchronous SRAM.
// Optional misaligned-redirect reporting is enabled with `define INST_FETCH_MISALIGN_EN.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int          AW       = 10,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic          CLK,
    input  logic          RST,
    output logic          IM_CSN,
    output logic [AW-1:0] IM_A,
    input  logic [31:0]   IM_DOUT,
    input  logic          redir_valid,
    input  logic [31:0]   redir_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_inst,
    output logic [31:0]   out_pc
`ifdef INST_FETCH_MISALIGN_EN
    ,
    output logic          out_misalign
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state;
    logic [31:0]   pc;
    logic [31:0]   req_pc_p1;
    logic          vld_p1;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic [63:0]   head;
    logic [63:0]   push_data;
    logic          req;
    logic          push;
    logic          pop;
    logic          stall;
    logic          mis_push;
    logic [31:0]   redir_tgt;

`ifdef INST_FETCH_MISALIGN_EN
    // A misaligned target parks fetch until the next redirect; its single NOP
    // entry is the only thing in the buffer while stalled.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stall <= 1'b0;
        else if (redir_valid)
            stall <= |redir_pc[1:0];
    end
    assign mis_push     = (state == ST_FLUSH) && stall && !redir_valid;
    assign redir_tgt    = redir_pc;
    assign out_misalign = out_valid && stall;
`else
    assign stall     = 1'b0;
    assign mis_push  = 1'b0;
    assign redir_tgt = redir_pc & ~32'h3;
`endif

    assign occupancy = {1'b0, count} + {{CW{1'b0}}, vld_p1};

    // Request decision deliberately ignores redir_valid: a request issued in a
    // redirect cycle is dropped because vld_p1 is cleared by the redirect.
    assign req = (state == ST_RUN) && !stall &&
                 ((occupancy < (CW+1)'(DEPTH)) ||
                  ((occupancy == (CW+1)'(DEPTH)) && (count != '0) && out_ready));

    assign IM_CSN = !req;
    assign IM_A   = pc[AW+1:2];

    assign out_valid = (count != '0) && !redir_valid;
    assign pop       = out_valid && out_ready;
    assign push      = (vld_p1 && !redir_valid) || mis_push;
    assign push_data = mis_push ? {pc, NOP_INST} : {req_pc_p1, IM_DOUT};
    assign out_pc    = out_valid ? head[63:32] : '0;
    assign out_inst  = out_valid ? head[31:0]  : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= ST_BOOT;
            pc     <= RESET_PC;
            vld_p1 <= 1'b0;
        end else if (redir_valid) begin
            state  <= ST_FLUSH;
            pc     <= redir_tgt;
            vld_p1 <= 1'b0;
        end else begin
            state  <= ST_RUN;
            vld_p1 <= req;
            if (req)
                pc <= pc_next(pc);
        end
    end

    // p0 -> p1: PC of the word the SRAM returns next cycle
    always_ff @(posedge CLK) begin
        if (req)
            req_pc_p1 <= pc;
    end

    fetch_buf #(
        .DEPTH  (DEPTH),
        .DATA_W (64)
    ) u_buf (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (redir_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head_data (head),
        .count     (count)
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch with a one-cycle synchronous SRAM model.
module tb_inst_fetch;

    localparam int AW = 10;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IM_CSN;
    logic [AW-1:0] IM_A;
    logic [31:0]   IM_DOUT;
    logic          redir_valid;
    logic [31:0]   redir_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc;
`ifdef INST_FETCH_MISALIGN_EN
    logic          out_misalign;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        mis;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] sram [1 << AW];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;

    inst_fetch #(.AW(AW), .RESET_PC(32'h0), .DEPTH(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IM_CSN      (IM_CSN),
        .IM_A        (IM_A),
        .IM_DOUT     (IM_DOUT),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc)
`ifdef INST_FETCH_MISALIGN_EN
        ,
        .out_misalign(out_misalign)
`endif
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!IM_CSN) IM_DOUT <= sram[IM_A];
        else         IM_DOUT <= 32'hDEAD_BEEF;
    end

    function automatic void push_exp(input logic [31:0] pc, input logic mis);
        exp_t e;
        e.pc   = pc;
        e.inst = mis ? 32'h0000_0013 : sram[pc[AW+1:2]];
        e.mis  = mis;
        sb.push_back(e);
    endfunction

    // Scoreboard: every accepted instruction must match the next expectation.
    always @(negedge CLK) begin
        if (mon_en && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got pc=%h inst=%h, no entry expected", out_pc, out_inst);
            end else begin
                exp_t e;
                logic mis_ok;
                e = sb.pop_front();
                mis_ok = 1'b1;
`ifdef INST_FETCH_MISALIGN_EN
                mis_ok = (out_misalign === e.mis);
`endif
                if (out_pc !== e.pc || out_inst !== e.inst || !mis_ok) begin
                    n_fail++;
                    $display("FAIL sb_entry: got pc=%h inst=%h, expected pc=%h inst=%h mis=%b",
                             out_pc, out_inst, e.pc, e.inst, e.mis);
                end
            end
        end
    end

    task automatic apply_reset(input logic ready);
        @(posedge CLK); #1;
        RST = 1'b1; out_ready = ready; redir_valid = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    task automatic test_reset;
        RST = 1'b1; out_ready = 1'b1; redir_valid = 1'b0; redir_pc = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_checks++;
        if (IM_CSN !== 1'b1 || out_valid !== 1'b0 || out_inst !== '0 || out_pc !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got csn=%b vld=%b inst=%h pc=%h, expected 1 0 0 0",
                     IM_CSN, out_valid, out_inst, out_pc);
        end
        push_exp(32'h0, 0); push_exp(32'h4, 0); push_exp(32'h8, 0); push_exp(32'hC, 0);
        mon_en = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        n_checks++;
        if (IM_CSN !== 1'b1) begin
            n_fail++;
            $display("FAIL boot_no_request: got csn=%b expected 1", IM_CSN);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            n_checks++;
            if (out_valid !== (k >= 3)) begin
                n_fail++;
                $display("FAIL first_valid cycle %0d: got %b expected %b", k, out_valid, (k >= 3));
            end
            if (k == 1) begin
                n_checks++;
                if (IM_CSN !== 1'b0 || IM_A !== '0) begin
                    n_fail++;
                    $display("FAIL first_request: got csn=%b a=%h expected 0 000", IM_CSN, IM_A);
                end
            end
        end
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL stream_drain: got %0d left expected 0", sb.size());
        end
        mon_en = 1'b0;
        sb.delete();
    endtask

    task automatic test_backpressure;
        int req_cnt = 0;
        apply_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (!IM_CSN) req_cnt++;
            if (i >= 3) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_inst !== 32'h11 || out_pc !== 32'h0 || IM_CSN !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_hold cycle %0d: got vld=%b inst=%h pc=%h csn=%b expected 1 11 0 1",
                             i, out_valid, out_inst, out_pc, IM_CSN);
                end
            end
            @(posedge CLK); #1;
        end
        n_checks++;
        if (req_cnt != 2) begin
            n_fail++;
            $display("FAIL stall_requests: got %0d expected 2", req_cnt);
        end
        push_exp(32'h0, 0); push_exp(32'h4, 0); push_exp(32'h8, 0);
        mon_en = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL resume_gap cycle %0d: got %b expected 1", k, out_valid);
            end
        end
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL resume_drain: got %0d left expected 0", sb.size());
        end
        mon_en = 1'b0;
        sb.delete();
    endtask

    task automatic test_redirect_inflight;
        apply_reset(1'b0);
        repeat (4) begin @(posedge CLK); #1; end
        push_exp(32'h0, 0);
        mon_en = 1'b1;
        out_ready = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (IM_CSN !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pop_request: got csn=%b expected 0", IM_CSN);
        end
        @(posedge CLK); #1;
        redir_valid = 1'b1; redir_pc = 32'h100;
        push_exp(32'h100, 0); push_exp(32'h104, 0);
        @(negedge CLK);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_cycle_valid: got %b expected 0", out_valid);
        end
        @(posedge CLK); #1;
        redir_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            n_checks++;
            if (out_valid !== (k == 3)) begin
                n_fail++;
                $display("FAIL redir_bubble cycle %0d: got %b expected %b", k, out_valid, (k == 3));
            end
            if (k < 3) begin @(posedge CLK); #1; end
        end
        #1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin @(negedge CLK); #1; end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL redir_drain: got %0d left expected 0", sb.size());
        end
        mon_en = 1'b0;
        sb.delete();
    endtask

    task automatic test_redirect_handshake;
        logic found = 1'b0;
        apply_reset(1'b1);
        push_exp(32'h0, 0); push_exp(32'h4, 0);
        mon_en = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge CLK); #1;
            if (out_valid && out_pc == 32'h8) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL head_pc8_timeout: got no head pc=8 expected one within 20 cycles");
        end
        redir_valid = 1'b1; redir_pc = 32'h200;
        push_exp(32'h200, 0); push_exp(32'h204, 0);
        @(negedge CLK);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_ready_valid: got %b expected 0", out_valid);
        end
        @(posedge CLK); #1;
        redir_valid = 1'b0;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin @(negedge CLK); #1; end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL redir_ready_drain: got %0d left expected 0", sb.size());
        end
        mon_en = 1'b0;
        sb.delete();
    endtask

    task automatic test_wrap;
        logic [AW-1:0] addrs[3];
        int            na = 0;
        apply_reset(1'b1);
        repeat (5) begin @(posedge CLK); #1; end
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFF8;
        push_exp(32'hFFFF_FFF8, 0); push_exp(32'hFFFF_FFFC, 0); push_exp(32'h0, 0);
        mon_en = 1'b1;
        @(posedge CLK); #1;
        redir_valid = 1'b0;
        for (int c = 0; c < 20 && (sb.size() > 0 || na < 3); c++) begin
            @(negedge CLK);
            if (!IM_CSN && na < 3) begin addrs[na] = IM_A; na++; end
            #1;
        end
        mon_en = 1'b0;
        n_checks++;
        if (sb.size() != 0 || na != 3) begin
            n_fail++;
            $display("FAIL wrap_drain: got %0d left, %0d requests, expected 0 and 3", sb.size(), na);
        end else begin
            n_checks++;
            if (addrs[0] !== 10'h3FE || addrs[1] !== 10'h3FF || addrs[2] !== 10'h000) begin
                n_fail++;
                $display("FAIL wrap_addr: got %h %h %h expected 3fe 3ff 000", addrs[0], addrs[1], addrs[2]);
            end
        end
        sb.delete();
    endtask

    task automatic test_midreset_misalign;
        int bad = 0;
        apply_reset(1'b1);
        repeat (6) begin @(posedge CLK); #1; end
        RST = 1'b1;
        #1;
        n_checks++;
        if (IM_CSN !== 1'b1 || out_valid !== 1'b0 || out_inst !== '0 || out_pc !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got csn=%b vld=%b inst=%h pc=%h expected 1 0 0 0",
                     IM_CSN, out_valid, out_inst, out_pc);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        push_exp(32'h0, 0); push_exp(32'h4, 0); push_exp(32'h8, 0);
        mon_en = 1'b1;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin @(negedge CLK); #1; end
        mon_en = 1'b0;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL restart_drain: got %0d left expected 0", sb.size());
        end
        sb.delete();
        @(posedge CLK); #1;
        redir_valid = 1'b1; redir_pc = 32'h102;
`ifdef INST_FETCH_MISALIGN_EN
        push_exp(32'h102, 1);
`else
        push_exp(32'h100, 0); push_exp(32'h104, 0);
`endif
        mon_en = 1'b1;
        @(posedge CLK); #1;
        redir_valid = 1'b0;
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin @(negedge CLK); #1; end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL low_bits_drain: got %0d left expected 0", sb.size());
        end
`ifdef INST_FETCH_MISALIGN_EN
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            if (!IM_CSN || out_valid) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL misalign_stall: got %0d active cycles expected 0", bad);
        end
`endif
        mon_en = 1'b0;
        sb.delete();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram[i] = 32'hA000_0000 | i;
        sram[0] = 32'h11; sram[1] = 32'h22; sram[2] = 32'h33; sram[3] = 32'h44;
        test_reset;
        test_backpressure;
        test_redirect_inflight;
        test_redirect_handshake;
        test_wrap;
        test_midreset_misalign;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
